mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the core's ready/valid memory interface (instmem_* and datamem_*); one instance per port in the SoC/testbench top.
- Holds a word-organised byte-maskable RAM, accepts one request per handshake, applies writes, returns read data after a fixed latency.
- Optional deterministic ready throttling for exercising core stall paths.

Parameters:
- Depth, 1024, number of Xlen-bit words; power of two.
- Latency, 1, cycles from read acceptance to mem_rvalid_o; legal range 1..8.
- ReadyPeriod, 0, 0 keeps ready high; N>0 drops ready for one cycle in every N cycles.
- InitFile, "", hex file loaded with $readmemh at time 0; empty means no load.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_ready_o  out  1  responder can accept a request this cycle.
- mem_valid_i  in  1  request valid.
- mem_addr_i  in  Xlen  byte address.
- mem_wdata_i  in  Xlen  write data.
- mem_wmask_i  in  MaskBits  byte write enables; all zero means read.
- mem_rdata_o  out  Xlen  read data, meaningful only while mem_rvalid_o is high.
- mem_rvalid_o  out  1  read response valid, one-cycle pulse per read.

Behaviour:
- Reset (rst_i low, asynchronous):
  - mem_rvalid_o=0, mem_rdata_o=0.
  - Latency pipe cleared and throttle counter=0.
  - mem_ready_o=1 if ReadyPeriod!=1, else 0.
  - RAM contents are NOT cleared.
- Accept: a request is accepted on a rising edge where mem_valid_i && mem_ready_o. No request queue; mem_ready_o does not depend combinationally on mem_valid_i.
- Address decode:
  - Word index = mem_addr_i[$clog2(Depth)+1:2]; bits [1:0] are ignored.
  - Out of range (mem_addr_i >= Depth*4): writes are dropped; reads return 0 with normal timing.
- Write (wmask!=0): on the accept edge, byte i is updated iff wmask[i]. No response; mem_rvalid_o is not raised.
- Read (wmask==0):
  - The word is sampled on the accept edge, so a write accepted on an earlier edge is visible.
  - The word enters a Latency-deep shift pipe (valid+data).
  - mem_rvalid_o/mem_rdata_o are driven from the pipe tail, giving rvalid exactly Latency cycles after the accept edge. Latency=1 means the cycle after acceptance.
- Back-to-back reads: one per cycle is legal; responses return in order, one per cycle, with no bubbles inserted.
- No response backpressure: the initiator must always sink rvalid.
- Throttle:
  - Free-running counter 0..ReadyPeriod-1, incrementing every cycle out of reset and wrapping to 0.
  - mem_ready_o=0 when counter==ReadyPeriod-1, else 1.
  - The pipe drains normally while ready is low.
- Reset mid-operation: in-flight read responses are discarded; no rvalid after reset release for requests accepted before reset.
- mem_rdata_o holds its last value when rvalid is low.

Decomposition:
- Xlen, MaskBits, Ilen come from core_pkg.
- Add to core_pkg: MaxMemLatency=8, used for parameter range checks.
- Sub-module valid_data_pipe (params Width, Depth): async active-low reset shift register of {valid,data}, reusable for latency modelling.
- RAM array, address decode, mask write and throttle stay in mem_responder.

Test Plan:
- Write then read, Latency=1: write 0xDEADBEEF mask 4'hF to 0x10, then read 0x10 -> rvalid exactly 1 cycle after read accept, rdata=0xDEADBEEF; no rvalid for the write.
- Byte mask: preload 0x11223344 at 0x20, write 0xAABBCCDD mask 4'b0101, read 0x20 -> 0x11BB33DD.
- Latency=3 streaming: reads of 0x0,0x4,0x8 on consecutive cycles (InitFile words 1,2,3) -> rvalid high 3 consecutive cycles starting 3 cycles after the first accept, data 1,2,3 in order.
- Throttle, ReadyPeriod=4: mem_valid_i held high -> ready pattern 1,1,1,0 repeating; exactly 3 accepts per 4 cycles; response count equals accepted reads.
- Out of range, Depth=16: write to 0x40 leaves all words unchanged; read 0x40 -> rdata=0 with normal latency.
- Reset mid-flight, Latency=4: read accepted, rst_i pulsed low 1 cycle later -> rvalid stays 0 for 8 cycles after release; RAM word still readable with its prior value.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core-wide widths and memory responder limits
package core_pkg;

    localparam int Xlen          = 32;
    localparam int MaskBits      = Xlen / 8;
    localparam int Ilen          = 32;
    // Longest read latency a memory responder may be configured with
    localparam int MaxMemLatency = 8;

endpackage

// File: rtl/valid_data_pipe.sv
// rtl/valid_data_pipe.sv - fixed-depth valid/data shift pipe for latency modelling
module valid_data_pipe #(
    parameter int Width = 32,
    parameter int Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Depth-1:0] vld;
    logic [Width-1:0] dat [Depth];

    // Shift valid every cycle; data only moves behind a valid beat so the tail holds its last value
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld <= '0;
            for (int i = 0; i < Depth; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= valid_i;
            if (valid_i) begin
                dat[0] <= data_i;
            end
            for (int i = 1; i < Depth; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign valid_o = vld[Depth-1];
    assign data_o  = dat[Depth-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-maskable word RAM responder with fixed read latency and ready throttling
module mem_responder
    import core_pkg::*;
#(
    parameter int    Depth       = 1024,
    parameter int    Latency     = 1,
    parameter int    ReadyPeriod = 0,
    parameter string InitFile    = ""
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                mem_ready_o,
    input  logic                mem_valid_i,
    input  logic [Xlen-1:0]     mem_addr_i,
    input  logic [Xlen-1:0]     mem_wdata_i,
    input  logic [MaskBits-1:0] mem_wmask_i,
    output logic [Xlen-1:0]     mem_rdata_o,
    output logic                mem_rvalid_o
);

    localparam int Aw = $clog2(Depth);

    if (Latency < 1 || Latency > MaxMemLatency) begin : g_bad_latency
        $error("mem_responder: Latency out of range");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: Depth must be a power of two >= 2");
    end

    logic [Xlen-1:0] mem [Depth];

    logic          accept;
    logic          is_write;
    logic          in_range;
    logic [Aw-1:0] word_idx;
    logic [Xlen-1:0] read_word;
    logic          unused_addr_bits;

    assign accept           = mem_valid_i && mem_ready_o && rst_i;
    assign is_write         = |mem_wmask_i;
    assign word_idx         = mem_addr_i[Aw+1:2];
    assign in_range         = (mem_addr_i[Xlen-1:Aw+2] == '0);
    assign read_word        = in_range ? mem[word_idx] : '0;
    assign unused_addr_bits = ^mem_addr_i[1:0];

    // Byte-masked write on the accept edge; out-of-range writes are dropped, contents survive reset
    always_ff @(posedge clk_i) begin
        if (accept && is_write && in_range) begin
            for (int b = 0; b < MaskBits; b++) begin
                if (mem_wmask_i[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    valid_data_pipe #(
        .Width (Xlen),
        .Depth (Latency)
    ) u_read_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (accept && !is_write),
        .data_i  (read_word),
        .valid_o (mem_rvalid_o),
        .data_o  (mem_rdata_o)
    );

    if (ReadyPeriod == 0) begin : g_no_throttle
        assign mem_ready_o = 1'b1;
    end else begin : g_throttle
        localparam int Cw = (ReadyPeriod > 1) ? $clog2(ReadyPeriod) : 1;
        localparam logic [Cw-1:0] Last = Cw'(ReadyPeriod - 1);

        logic [Cw-1:0] cnt;

        // Free-running phase counter; ready drops for the last slot of each period
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                cnt <= '0;
            end else if (cnt == Last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign mem_ready_o = (cnt != Last);
    end

endmodule
